// File: rtl/gmii_tx_arbiter_if.sv
// FIFO-side and GMII-side signals of the two-source TX arbiter.
// master: the arbiter; slave: the FIFOs and the TX pins.
interface gmii_tx_arbiter_if;
    logic       a_fifo_empty;
    logic       a_fifo_en;
    logic [7:0] a_fifo_d;
    logic       a_fifo_er;
    logic       a_fifo_frame_end;
    logic       b_fifo_empty;
    logic       b_fifo_en;
    logic [7:0] b_fifo_d;
    logic       b_fifo_er;
    logic       b_fifo_frame_end;
    logic       tx_en;
    logic [7:0] txd;
    logic       tx_er;

    modport master (
        input  a_fifo_empty, a_fifo_d, a_fifo_er, a_fifo_frame_end,
        input  b_fifo_empty, b_fifo_d, b_fifo_er, b_fifo_frame_end,
        output a_fifo_en, b_fifo_en, tx_en, txd, tx_er
    );

    modport slave (
        output a_fifo_empty, a_fifo_d, a_fifo_er, a_fifo_frame_end,
        output b_fifo_empty, b_fifo_d, b_fifo_er, b_fifo_frame_end,
        input  a_fifo_en, b_fifo_en, tx_en, txd, tx_er
    );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// Per-frame round-robin arbiter feeding one GMII TX port from two frame FIFOs,
// with prefill before each frame, minimum inter-frame gap and underflow recovery.
//
// state   | meaning
// IDLE    | waiting for a request; grant decided here
// PREFILL | letting the granted FIFO fill up, no pops
// TX      | popping and transmitting bytes of the granted frame
// DRAIN   | after underflow, discarding the rest of the frame silently
// IFG     | enforcing the inter-frame gap
module gmii_tx_arbiter #(
    parameter int unsigned PREFILL_CYCLES = 32,
    parameter int unsigned IFG_CYCLES     = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          port_enable,
    input  logic                underflow_clr,
    gmii_tx_arbiter_if.master   bus,
    output logic                grant,
    output logic                busy,
    output logic                underflow,
    output logic [15:0]         a_frame_count,
    output logic [15:0]         b_frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_TX,
        S_DRAIN,
        S_IFG
    } state_t;

    state_t     state, state_next;
    logic [5:0] timer, timer_next;
    logic       last_grant, last_grant_next;
    logic       grant_next;
    logic       pop;
    logic       tx_en_next, tx_er_next;
    logic [7:0] txd_next;
    logic       underflow_set;
    logic       count_inc;
    logic [1:0] req;

    logic       sel_empty;
    logic [7:0] sel_d;
    logic       sel_er;
    logic       sel_fe;

    assign sel_empty = grant ? bus.b_fifo_empty     : bus.a_fifo_empty;
    assign sel_d     = grant ? bus.b_fifo_d         : bus.a_fifo_d;
    assign sel_er    = grant ? bus.b_fifo_er        : bus.a_fifo_er;
    assign sel_fe    = grant ? bus.b_fifo_frame_end : bus.a_fifo_frame_end;

    assign req = ~{bus.b_fifo_empty, bus.a_fifo_empty} & port_enable;

    // Pops are cut combinationally by reset so no byte is lost during the reset edge.
    assign bus.a_fifo_en = pop & ~grant & ~reset;
    assign bus.b_fifo_en = pop &  grant & ~reset;

    assign busy = (state != S_IDLE);

    always_comb begin
        state_next      = state;
        timer_next      = timer;
        grant_next      = grant;
        last_grant_next = last_grant;
        pop             = 1'b0;
        tx_en_next      = 1'b0;
        tx_er_next      = 1'b0;
        txd_next        = 8'h00;
        underflow_set   = 1'b0;
        count_inc       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_next      = (req == 2'b11) ? ~last_grant : req[1];
                    last_grant_next = grant_next;
                    timer_next      = 6'(PREFILL_CYCLES - 1);
                    state_next      = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (timer == 6'd0) state_next = S_TX;
                else               timer_next = timer - 6'd1;
            end
            S_TX: begin
                tx_en_next = 1'b1;
                if (!sel_empty) begin
                    pop        = 1'b1;
                    txd_next   = sel_d;
                    tx_er_next = sel_er;
                    if (sel_fe) begin
                        count_inc  = 1'b1;
                        timer_next = 6'(IFG_CYCLES);
                        state_next = S_IFG;
                    end
                end else begin
                    // Mid-frame starvation: mark the frame bad with one error cycle.
                    tx_er_next    = 1'b1;
                    underflow_set = 1'b1;
                    state_next    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!sel_empty) begin
                    pop = 1'b1;
                    if (sel_fe) begin
                        timer_next = 6'(IFG_CYCLES);
                        state_next = S_IFG;
                    end
                end
            end
            S_IFG: begin
                if (timer == 6'd0) state_next = S_IDLE;
                else               timer_next = timer - 6'd1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= 6'd0;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            bus.tx_en     <= 1'b0;
            bus.txd       <= 8'h00;
            bus.tx_er     <= 1'b0;
            underflow     <= 1'b0;
            a_frame_count <= 16'd0;
            b_frame_count <= 16'd0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            bus.tx_en  <= tx_en_next;
            bus.txd    <= txd_next;
            bus.tx_er  <= tx_er_next;
            if (underflow_set)      underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
            if (count_inc) begin
                if (grant) b_frame_count <= b_frame_count + 16'd1;
                else       a_frame_count <= a_frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: FIFO models feed frames, expected GMII
// bytes are queued in transmit order and checked by an independent monitor.
module tb_gmii_tx_arbiter;
    localparam int PREFILL = 32;
    localparam int IFG     = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  port_enable = 2'b11;
    logic        clr_stim = 1'b0;
    logic        clr_model = 1'b0;
    logic        underflow_clr;
    logic        grant, busy, underflow;
    logic [15:0] a_cnt, b_cnt;

    assign underflow_clr = clr_stim | clr_model;

    gmii_tx_arbiter_if bus ();

    gmii_tx_arbiter #(.PREFILL_CYCLES(PREFILL), .IFG_CYCLES(IFG)) dut (
        .clock         (clock),
        .reset         (reset),
        .port_enable   (port_enable),
        .underflow_clr (underflow_clr),
        .bus           (bus),
        .grant         (grant),
        .busy          (busy),
        .underflow     (underflow),
        .a_frame_count (a_cnt),
        .b_frame_count (b_cnt)
    );

    always #4 clock = ~clock;

    // FIFO entries {frame_end, er, d}; scoreboard entries {last, er, d}
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] exp_q[$];

    int checks = 0;
    int failures = 0;
    int a_pops = 0;
    int a_stall_at = -1;
    int a_stall_len = 0;
    int a_stall = 0;
    bit clr_on_stall = 1'b0;
    bit in_frame = 1'b0;
    bit seen_tx = 1'b0;
    int idle_run = 0;
    int tx_bytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        bus.a_fifo_empty     = (qa.size() == 0) || (a_stall > 0);
        bus.a_fifo_d         = (qa.size() != 0) ? qa[0][7:0] : 8'h00;
        bus.a_fifo_er        = (qa.size() != 0) ? qa[0][8]   : 1'b0;
        bus.a_fifo_frame_end = (qa.size() != 0) ? qa[0][9]   : 1'b0;
        bus.b_fifo_empty     = (qb.size() == 0);
        bus.b_fifo_d         = (qb.size() != 0) ? qb[0][7:0] : 8'h00;
        bus.b_fifo_er        = (qb.size() != 0) ? qb[0][8]   : 1'b0;
        bus.b_fifo_frame_end = (qb.size() != 0) ? qb[0][9]   : 1'b0;
    endtask

    task automatic push_fifo(input int src, input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++) begin
            logic [9:0] e;
            e = {(i == len - 1), (i == 5), seed + 8'(i)};
            if (src == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
        refresh();
    endtask

    task automatic push_exp(input int len, input logic [7:0] seed, input bit whole);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(whole && i == len - 1), (i == 5), seed + 8'(i)});
    endtask

    task automatic push_frame(input int src, input int len, input logic [7:0] seed);
        push_fifo(src, len, seed);
        push_exp(len, seed, 1'b1);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        tick();
        tick();
        while (!(busy == 1'b0 && exp_q.size() == 0) && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL %s timeout busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        in_frame = 1'b0;
        seen_tx = 1'b0;
        idle_run = 0;
        exp_q.delete();
        qa.delete();
        qb.delete();
        a_stall = 0;
        a_stall_at = -1;
        refresh();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // FIFO model: pops sampled at the edge, new head presented just after it.
    always @(posedge clock) begin
        logic pa, pb;
        pa = bus.a_fifo_en;
        pb = bus.b_fifo_en;
        #1;
        clr_model = 1'b0;
        if (a_stall > 0) a_stall--;
        if (pa && qa.size() != 0) begin
            void'(qa.pop_front());
            a_pops++;
            if (a_pops == a_stall_at) begin
                a_stall   = a_stall_len;
                clr_model = clr_on_stall;
            end
        end
        if (pb && qb.size() != 0) void'(qb.pop_front());
        refresh();
    end

    // Monitor
    always @(negedge clock) begin
        logic [9:0] e;
        check("fifo_en_rule",
              32'((bus.a_fifo_en && bus.a_fifo_empty) || (bus.b_fifo_en && bus.b_fifo_empty) ||
                  (bus.a_fifo_en && bus.b_fifo_en)), 32'd0);
        if (bus.tx_en) begin
            if (!in_frame && seen_tx)
                check("ifg_gap", 32'(idle_run >= IFG + 1), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual=%0b_%0h expected=no transmission", bus.tx_er, bus.txd);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'({bus.tx_er, bus.txd}), 32'(e[8:0]));
                in_frame = !e[9];
            end
            idle_run = 0;
            seen_tx = 1'b1;
            tx_bytes++;
        end else begin
            if (in_frame) begin
                checks++;
                failures++;
                $display("FAIL frame_gap actual=tx_en 0 expected=tx_en 1 (pending=%0d)", exp_q.size());
                in_frame = 1'b0;
            end
            idle_run++;
        end
    end

    initial begin
        refresh();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_txd", 32'(bus.txd), 32'd0);
        check("rst_tx_er", 32'(bus.tx_er), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_cnt", 32'(b_cnt), 32'd0);

        // single 64-byte frame on A, latency from the grant cycle
        push_frame(0, 64, 8'h40);
        repeat (PREFILL + 1) tick();
        check("latency_early", 32'(bus.tx_en), 32'd0);
        tick();
        check("latency_first", 32'(bus.tx_en), 32'd1);
        wait_done("t1_done");
        check("t1_a_cnt", 32'(a_cnt), 32'd1);
        check("t1_b_cnt", 32'(b_cnt), 32'd0);
        check("t1_grant", 32'(grant), 32'd0);

        // both sources from reset: A wins the tie, then B
        do_reset();
        push_frame(0, 60, 8'h80);
        push_frame(1, 60, 8'hC0);
        wait_done("t2_done");
        check("t2_a_cnt", 32'(a_cnt), 32'd1);
        check("t2_b_cnt", 32'(b_cnt), 32'd1);
        check("t2_grant", 32'(grant), 32'd1);

        // round robin over three frames each
        push_fifo(0, 1, 8'h10);
        push_fifo(0, 7, 8'h20);
        push_fifo(0, 12, 8'h30);
        push_fifo(1, 3, 8'h50);
        push_fifo(1, 8, 8'h60);
        push_fifo(1, 1, 8'h70);
        push_exp(1, 8'h10, 1'b1);
        push_exp(3, 8'h50, 1'b1);
        push_exp(7, 8'h20, 1'b1);
        push_exp(8, 8'h60, 1'b1);
        push_exp(12, 8'h30, 1'b1);
        push_exp(1, 8'h70, 1'b1);
        wait_done("t3_rr");
        check("t3_a_cnt", 32'(a_cnt), 32'd4);
        check("t3_b_cnt", 32'(b_cnt), 32'd4);

        // B disabled: only A frames go out, B stays queued
        port_enable = 2'b01;
        push_fifo(0, 4, 8'h90);
        push_fifo(0, 5, 8'hA0);
        push_fifo(1, 6, 8'hB0);
        push_exp(4, 8'h90, 1'b1);
        push_exp(5, 8'hA0, 1'b1);
        wait_done("t3_masked");
        repeat (60) tick();
        check("t3m_a_cnt", 32'(a_cnt), 32'd6);
        check("t3m_b_cnt", 32'(b_cnt), 32'd4);
        check("t3m_b_queued", 32'(qb.size()), 32'd6);
        check("t3m_busy", 32'(busy), 32'd0);
        push_exp(6, 8'hB0, 1'b1);
        port_enable = 2'b11;
        wait_done("t3_reenabled");
        check("t3r_b_cnt", 32'(b_cnt), 32'd5);

        // underflow after byte 40 for 5 cycles
        do_reset();
        a_pops = 0;
        a_stall_at = 40;
        a_stall_len = 5;
        clr_on_stall = 1'b0;
        push_fifo(0, 100, 8'h00);
        push_exp(40, 8'h00, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 8'h00});
        wait_done("t4_underflow");
        a_stall_at = -1;
        check("t4_underflow", 32'(underflow), 32'd1);
        check("t4_a_cnt", 32'(a_cnt), 32'd0);
        check("t4_drained", 32'(qa.size()), 32'd0);
        push_frame(0, 10, 8'hE0);
        wait_done("t4_next");
        check("t4n_a_cnt", 32'(a_cnt), 32'd1);
        check("t4n_underflow", 32'(underflow), 32'd1);

        // reset at byte 20 of a frame
        tx_bytes = 0;
        push_frame(0, 50, 8'h20);
        for (int n = 0; n < 400 && tx_bytes < 20; n++) tick();
        check("t5_reached_byte20", 32'(tx_bytes), 32'd20);
        reset = 1'b1;
        in_frame = 1'b0;
        seen_tx = 1'b0;
        exp_q.delete();
        #1;
        check("t5_pop_stop", 32'(bus.a_fifo_en), 32'd0);
        tick();
        check("t5_tx_en", 32'(bus.tx_en), 32'd0);
        check("t5_a_cnt", 32'(a_cnt), 32'd0);
        check("t5_b_cnt", 32'(b_cnt), 32'd0);
        check("t5_underflow", 32'(underflow), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        qa.delete();
        qb.delete();
        refresh();
        tick();
        reset = 1'b0;
        push_frame(0, 4, 8'h11);
        push_frame(1, 4, 8'h22);
        wait_done("t5_tie");
        check("t5t_a_cnt", 32'(a_cnt), 32'd1);
        check("t5t_b_cnt", 32'(b_cnt), 32'd1);

        // underflow_clr coinciding with a new underflow: set wins
        a_pops = 0;
        a_stall_at = 40;
        a_stall_len = 5;
        clr_on_stall = 1'b1;
        push_fifo(0, 50, 8'h70);
        push_exp(40, 8'h70, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 8'h00});
        wait_done("t6_underflow");
        a_stall_at = -1;
        clr_on_stall = 1'b0;
        check("t6_set_wins", 32'(underflow), 32'd1);
        check("t6_a_cnt", 32'(a_cnt), 32'd1);
        clr_stim = 1'b1;
        tick();
        clr_stim = 1'b0;
        check("t6_clr", 32'(underflow), 32'd0);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
